calc_sequencer: RTL and testbench

Hardware replacement for the bench-side stimulus driver of the 16-bit CPU calculator flow. On a start request it latches two operands and an operation, then presents the word stream operand1, operand2, opcode, OUTA to the input-register data port, holding each word for a fixed number of clocks. After a settle window it samples the CPU's `out_led` bus into `result`. It sits between a user/host front end and the `IO_REG` feeding the CPU's `IN_REG_out`.

---
 rtl/calc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Word-stream sequencer for the 16-bit CPU calculator: streams operands, opcode and OUTA
// into IO_REG, waits for the CPU to settle, then captures out_led into result.
module calc_sequencer #(
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op_sel,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  input  logic [15:0] out_led,
  output logic [15:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        err,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  localparam int MAX_CNT = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_RELOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [15:0] OPC_ADD  = 16'h3000;
  localparam logic [15:0] OPC_SUB  = 16'h5000;
  localparam logic [15:0] OPC_MUL  = 16'h6000;
  localparam logic [15:0] OPC_DIV  = 16'h7000;
  localparam logic [15:0] OPC_MOD  = 16'h8000;
  localparam logic [15:0] OPC_OUTA = 16'h4000;
  localparam logic [15:0] OPC_HALT = 16'hF000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_NUM1,
    S_W_NUM2,
    S_W_OPC,
    S_W_OUTA,
    S_W_HALT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [15:0]      num1_q, num1_d;
  logic [15:0]      num2_q, num2_d;
  logic [15:0]      opc_q, opc_d;
  logic             halt_path_q, halt_path_d;
  logic [15:0]      in_data_d;
  logic             busy_d, done_d, err_d, halted_d, result_valid_d;
  logic [15:0]      result_d;
  logic             arith_legal;
  logic [15:0]      arith_word;

  assign state_dbg = state;

  always_comb begin
    arith_legal = 1'b1;
    arith_word  = OPC_ADD;
    case (op_sel)
      3'd0:    arith_word = OPC_ADD;
      3'd1:    arith_word = OPC_SUB;
      3'd2:    arith_word = OPC_MUL;
      3'd3:    arith_word = OPC_DIV;
      3'd4:    arith_word = OPC_MOD;
      default: arith_legal = 1'b0;
    endcase
  end

  // start is a request sampled each clock; it is taken only in IDLE with halted low.
  // There is no ready output: a start seen in any other state is simply dropped.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    num1_d         = num1_q;
    num2_d         = num2_q;
    opc_d          = opc_q;
    halt_path_d    = halt_path_q;
    result_d       = result;
    result_valid_d = result_valid;
    halted_d       = halted;
    err_d          = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !halted) begin
          if (op_sel == 3'd7) begin
            state_d     = S_W_HALT;
            cnt_d       = HOLD_RELOAD;
            halt_path_d = 1'b1;
          end else if (arith_legal) begin
            state_d        = S_W_NUM1;
            cnt_d          = HOLD_RELOAD;
            halt_path_d    = 1'b0;
            num1_d         = num1;
            num2_d         = num2;
            opc_d          = arith_word;
            result_valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_W_NUM1, S_W_NUM2, S_W_OPC, S_W_OUTA, S_W_HALT: begin
        if (cnt == '0) begin
          cnt_d = HOLD_RELOAD;
          case (state)
            S_W_NUM1: state_d = S_W_NUM2;
            S_W_NUM2: state_d = S_W_OPC;
            S_W_OPC:  state_d = S_W_OUTA;
            default: begin
              state_d = S_SETTLE;
              cnt_d   = SETTLE_RELOAD;
            end
          endcase
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_d = S_DONE;
          if (halt_path_q) begin
            halted_d = 1'b1;
          end else begin
            result_d       = out_led;
            result_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    in_data_d = 16'h0000;
    case (state_d)
      S_W_NUM1: in_data_d = num1_d;
      S_W_NUM2: in_data_d = num2_d;
      S_W_OPC:  in_data_d = opc_d;
      S_W_OUTA: in_data_d = OPC_OUTA;
      S_W_HALT: in_data_d = OPC_HALT;
      default:  in_data_d = 16'h0000;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      num1_q       <= '0;
      num2_q       <= '0;
      opc_q        <= '0;
      halt_path_q  <= 1'b0;
      in_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      num1_q       <= num1_d;
      num2_q       <= num2_d;
      opc_q        <= opc_d;
      halt_path_q  <= halt_path_d;
      in_data      <= in_data_d;
      busy         <= busy_d;
      done         <= done_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      err          <= err_d;
      halted       <= halted_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a small CPU model answers on out_led from the observed word
// stream, and expected results are queued at start and popped when done arrives.
module tb_calc_sequencer;

  localparam int H    = 4;
  localparam int S    = 10;
  localparam int LAST = 4 * H + S;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op_sel;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [15:0] out_led;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        result_valid;
  logic        err;
  logic        halted;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  calc_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_sel       (op_sel),
    .num1         (num1),
    .num2         (num2),
    .out_led      (out_led),
    .in_data      (in_data),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CPU model: decodes the opcode word it received and computes on the received operands
  function automatic logic [15:0] cpu_calc(input logic [15:0] opc, input logic [15:0] a,
                                           input logic [15:0] b);
    case (opc)
      16'h3000: cpu_calc = a + b;
      16'h5000: cpu_calc = a - b;
      16'h6000: cpu_calc = a * b;
      16'h7000: cpu_calc = (b == 0) ? 16'hFFFF : a / b;
      16'h8000: cpu_calc = (b == 0) ? a : a % b;
      default:  cpu_calc = 16'hBAD0;
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_in_data"}, 32'(in_data), 32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_done"}, 32'(done), 32'h0);
    check_val({tag, "_result"}, 32'(result), 32'h0);
    check_val({tag, "_rvalid"}, 32'(result_valid), 32'h0);
    check_val({tag, "_err"}, 32'(err), 32'h0);
    check_val({tag, "_halted"}, 32'(halted), 32'h0);
  endtask

  // driver: one arithmetic sequence, checked cycle by cycle from the accept edge
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] opc_word, input logic [15:0] exp_res,
                        input bit disturb);
    logic [15:0] obs1, obs2, obs_opc, exp_word, got_exp;
    obs1 = '0; obs2 = '0; obs_opc = '0;
    @(negedge clk);
    start   = 1'b1;
    op_sel  = op;
    num1    = a;
    num2    = b;
    out_led = 16'hDEAD;
    exp_q.push_back(exp_res);
    for (int c = 0; c <= LAST; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start = 1'b0;
      if (c < H) exp_word = a;
      else if (c < 2 * H) exp_word = b;
      else if (c < 3 * H) exp_word = opc_word;
      else if (c < 4 * H) exp_word = 16'h4000;
      else exp_word = 16'h0000;
      check_val($sformatf("in_data_c%0d", c), 32'(in_data), 32'(exp_word));
      check_val($sformatf("busy_c%0d", c), 32'(busy), 32'h1);
      check_val($sformatf("done_c%0d", c), 32'(done), (c == LAST) ? 32'h1 : 32'h0);
      if (c < LAST) check_val($sformatf("rvalid_c%0d", c), 32'(result_valid), 32'h0);
      if (c == 0) obs1 = in_data;
      if (c == H) obs2 = in_data;
      if (c == 2 * H) obs_opc = in_data;
      if (c == 4 * H) out_led = cpu_calc(obs_opc, obs1, obs2);
      if (disturb && c == 5) begin
        start  = 1'b1;
        num1   = 16'd99;
        num2   = 16'd99;
        op_sel = 3'd2;
      end
      if (disturb && c == 6) start = 1'b0;
    end
    check_val("sb_size", 32'(exp_q.size()), 32'd1);
    got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    check_val("result", 32'(result), 32'(got_exp));
    check_val("result_valid", 32'(result_valid), 32'h1);
    @(posedge clk);
    #1;
    check_val("busy_after", 32'(busy), 32'h0);
    check_val("done_after", 32'(done), 32'h0);
    check_val("in_data_after", 32'(in_data), 32'h0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op_sel  = 3'd0;
    num1    = '0;
    num2    = '0;
    out_led = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // ADD then back-to-back SUB, MUL, DIV, MOD
    run_op(3'd0, 16'd20, 16'd6, 16'h3000, 16'd26, 1'b0);
    run_op(3'd1, 16'd20, 16'd6, 16'h5000, 16'd14, 1'b0);
    run_op(3'd2, 16'd20, 16'd6, 16'h6000, 16'd120, 1'b0);
    run_op(3'd3, 16'd20, 16'd6, 16'h7000, 16'd3, 1'b0);
    run_op(3'd4, 16'd20, 16'd6, 16'h8000, 16'd2, 1'b0);

    // start and operand changes while busy are ignored
    run_op(3'd0, 16'd20, 16'd6, 16'h3000, 16'd26, 1'b1);

    // illegal op: err pulse only, nothing latched
    @(negedge clk);
    start  = 1'b1;
    op_sel = 3'd5;
    num1   = 16'd7;
    num2   = 16'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("err_pulse", 32'(err), 32'h1);
    check_val("err_busy", 32'(busy), 32'h0);
    check_val("err_in_data", 32'(in_data), 32'h0);
    check_val("err_result", 32'(result), 32'd26);
    check_val("err_rvalid", 32'(result_valid), 32'h1);
    @(posedge clk);
    #1;
    check_val("err_clear", 32'(err), 32'h0);
    check_val("err_busy2", 32'(busy), 32'h0);

    // reset in the middle of W_OPC aborts at once
    @(negedge clk);
    start  = 1'b1;
    op_sel = 3'd0;
    num1   = 16'd20;
    num2   = 16'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2 * H + 1) @(posedge clk);
    #1;
    check_val("abort_pre_opc", 32'(in_data), 32'h3000);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("abort_hold");
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 16'd20, 16'd6, 16'h3000, 16'd26, 1'b0);

    // HALT path
    @(negedge clk);
    start  = 1'b1;
    op_sel = 3'd7;
    for (int c = 0; c <= H + S; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start = 1'b0;
      check_val($sformatf("halt_in_data_c%0d", c), 32'(in_data), (c < H) ? 32'hF000 : 32'h0);
      check_val($sformatf("halt_done_c%0d", c), 32'(done), (c == H + S) ? 32'h1 : 32'h0);
      check_val($sformatf("halt_flag_c%0d", c), 32'(halted), (c == H + S) ? 32'h1 : 32'h0);
      check_val($sformatf("halt_busy_c%0d", c), 32'(busy), 32'h1);
    end
    @(posedge clk);
    #1;
    check_val("halt_busy_after", 32'(busy), 32'h0);
    check_val("halt_sticky", 32'(halted), 32'h1);
    check_val("halt_result_kept", 32'(result), 32'd26);

    // start while halted is ignored without err
    @(negedge clk);
    start  = 1'b1;
    op_sel = 3'(($urandom_range(0, 1) == 0) ? 0 : 5);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("halted_busy_c%0d", c), 32'(busy), 32'h0);
      check_val($sformatf("halted_err_c%0d", c), 32'(err), 32'h0);
      check_val($sformatf("halted_in_data_c%0d", c), 32'(in_data), 32'h0);
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
